// File: rtl/sobel_mac_seq.sv
// Sequencer that drives one external registered MAC to compute a 3x3 Sobel
// gradient magnitude: 9 chained taps for Gx, 9 for Gy, then clip(|Gx|+|Gy|).
module sobel_mac_seq #(
  parameter int N     = 16,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [9*PIX_W-1:0] in_window,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_data,
  output logic [N-1:0]       mac_a,
  output logic [N-1:0]       mac_b,
  output logic [N-1:0]       mac_c,
  output logic               mac_ce,
  output logic               mac_sclr,
  input  logic [N-1:0]       mac_p
);

  typedef enum logic [2:0] {
    IDLE,
    RUN_X,
    SAVE_X,
    RUN_Y,
    SAVE_Y,
    OUT
  } state_t;

  localparam logic [N-1:0] CM2 = N'(-2);
  localparam logic [N-1:0] CM1 = N'(-1);
  localparam logic [N-1:0] CP1 = N'(1);
  localparam logic [N-1:0] CP2 = N'(2);
  localparam logic [N:0]   PIX_MAX = (N+1)'((1 << PIX_W) - 1);

  state_t             state_q, state_d;
  logic [3:0]         tap_q, tap_d;
  logic [PIX_W-1:0]   pix_q [9];
  logic [PIX_W-1:0]   pix_d [9];
  logic [N-1:0]       gx_q, gx_d;
  logic [PIX_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               sclr_q;

  logic [N:0]         gx_ext, gy_ext, abs_x, abs_y, mag;

  function automatic logic [N-1:0] coef_x(input logic [3:0] k);
    case (k)
      4'd0, 4'd6: coef_x = CM1;
      4'd3:       coef_x = CM2;
      4'd2, 4'd8: coef_x = CP1;
      4'd5:       coef_x = CP2;
      default:    coef_x = '0;
    endcase
  endfunction

  function automatic logic [N-1:0] coef_y(input logic [3:0] k);
    case (k)
      4'd0, 4'd2: coef_y = CM1;
      4'd1:       coef_y = CM2;
      4'd6, 4'd8: coef_y = CP1;
      4'd7:       coef_y = CP2;
      default:    coef_y = '0;
    endcase
  endfunction

  // Magnitude is formed one bit wider than the MAC so |-2^(N-1)| cannot wrap.
  always_comb begin
    gx_ext = {gx_q[N-1], gx_q};
    gy_ext = {mac_p[N-1], mac_p};
    abs_x  = gx_ext[N] ? -gx_ext : gx_ext;
    abs_y  = gy_ext[N] ? -gy_ext : gy_ext;
    mag    = abs_x + abs_y;
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    pix_d       = pix_q;
    gx_d        = gx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mac_ce      = 1'b0;
    mac_a       = '0;
    mac_b       = '0;
    mac_c       = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < 9; k++) begin
            pix_d[k] = in_window[k*PIX_W +: PIX_W];
          end
          tap_d   = 4'd0;
          state_d = RUN_X;
        end
      end
      RUN_X, RUN_Y: begin
        mac_ce = 1'b1;
        mac_a  = {{(N-PIX_W){1'b0}}, pix_q[tap_q]};
        mac_b  = (state_q == RUN_X) ? coef_x(tap_q) : coef_y(tap_q);
        // Tap 0 starts a fresh sum; later taps chain the previous product.
        mac_c  = (tap_q == 4'd0) ? '0 : mac_p;
        if (tap_q == 4'd8) begin
          tap_d   = 4'd0;
          state_d = (state_q == RUN_X) ? SAVE_X : SAVE_Y;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      SAVE_X: begin
        gx_d    = mac_p;
        tap_d   = 4'd0;
        state_d = RUN_Y;
      end
      SAVE_Y: begin
        out_data_d  = (mag > PIX_MAX) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tap_q       <= 4'd0;
      gx_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        pix_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      gx_q        <= gx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pix_q       <= pix_d;
    end
  end

  // The MAC is only ever cleared by reset; normal sums restart through mac_c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclr_q <= 1'b1;
    end else begin
      sclr_q <= 1'b0;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign mac_sclr  = sclr_q;

endmodule

// File: tb/tb_sobel_mac_seq.sv
// Bench for sobel_mac_seq: models the external MAC, predicts each magnitude
// from the kernels directly and checks the per-cycle MAC issue trace.
module tb_sobel_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_window;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] mac_a, mac_b, mac_c, mac_p;
  logic        mac_ce, mac_sclr;

  int vectors = 0;
  int miscompares = 0;

  int kx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int ky [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  int          expQ [$];
  bit          busy = 0;
  int          tAcc = 0;
  int          negCyc = 0;
  logic [71:0] curWin = '0;
  bit          holding = 0;
  logic [7:0]  heldData = '0;

  sobel_mac_seq #(.N(16), .PIX_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_window (in_window),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_c     (mac_c),
    .mac_ce    (mac_ce),
    .mac_sclr  (mac_sclr),
    .mac_p     (mac_p)
  );

  always #5 clk = ~clk;

  // Behavioural registered MAC: p <= a*b + c truncated, sync clear, enable.
  always @(posedge clk) begin
    if (mac_sclr) mac_p <= '0;
    else if (mac_ce) mac_p <= 16'(mac_a * mac_b + mac_c);
  end

  function automatic int pixOf(input logic [71:0] w, input int k);
    return int'(w[k*8 +: 8]);
  endfunction

  function automatic int refMag(input logic [71:0] w);
    int gx = 0;
    int gy = 0;
    int m;
    for (int k = 0; k < 9; k++) begin
      gx += pixOf(w, k) * kx[k];
      gy += pixOf(w, k) * ky[k];
    end
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic logic [71:0] mkWin(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
    return {8'(p8), 8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: scoreboard pops on the output handshake, plus per-cycle trace checks.
  always @(negedge clk) begin
    int off;
    int k;
    negCyc++;
    if (!rst_n) begin
      checkOutput("rstOutValid", int'(out_valid), 0);
      checkOutput("rstSclr", int'(mac_sclr), 1);
      expQ.delete();
      busy = 0;
      holding = 0;
    end else begin
      if (busy) begin
        off = negCyc - tAcc;
        checkOutput("busyInReady", int'(in_ready), 0);
        checkOutput("busySclr", int'(mac_sclr), 0);
        if ((off >= 1 && off <= 9) || (off >= 11 && off <= 19)) begin
          k = (off <= 9) ? off - 1 : off - 11;
          checkOutput("issueCe", int'(mac_ce), 1);
          checkOutput("issueA", int'(mac_a), pixOf(curWin, k));
          checkOutput("issueB", int'($signed(mac_b)), (off <= 9) ? kx[k] : ky[k]);
          checkOutput("issueC", int'(mac_c), (k == 0) ? 0 : int'(mac_p));
        end else begin
          checkOutput("idleCe", int'(mac_ce), 0);
        end
        if (off < 21) checkOutput("earlyValid", int'(out_valid), 0);
        if (off == 21) checkOutput("latencyValid", int'(out_valid), 1);
      end
      if (out_valid && !out_ready) begin
        if (holding) checkOutput("holdData", int'(out_data), int'(heldData));
        heldData = out_data;
        holding = 1;
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOut", 1, 0);
        end else begin
          checkOutput("outData", int'(out_data), expQ.pop_front());
        end
        busy = 0;
        holding = 0;
      end
      if (in_valid && in_ready) begin
        checkOutput("acceptWhileBusy", int'(busy), 0);
        expQ.push_back(refMag(in_window));
        curWin = in_window;
        tAcc = negCyc;
        busy = 1;
      end
    end
  end

  task automatic applyStimulus(input logic [71:0] w);
    bit accepted = 0;
    in_window = w;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready && rst_n) accepted = 1;
    end
    if (!accepted) checkOutput("acceptTimeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_window = 72'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic waitValid();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) checkOutput("validTimeout", 0, 1);
  endtask

  task automatic waitDone();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy && expQ.size() == 0) done = 1;
    end
    if (!done) checkOutput("doneTimeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [71:0] w;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_window = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetOutValid", int'(out_valid), 0);
    checkOutput("resetOutData", int'(out_data), 0);
    checkOutput("resetCe", int'(mac_ce), 0);
    checkOutput("resetA", int'(mac_a), 0);
    checkOutput("resetB", int'(mac_b), 0);
    checkOutput("resetC", int'(mac_c), 0);
    checkOutput("resetSclr", int'(mac_sclr), 1);
    checkOutput("resetInReady", int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("sclrAfterRelease", int'(mac_sclr), 0);

    $display("[TB] directed windows");
    applyStimulus(mkWin(100, 100, 100, 100, 100, 100, 100, 100, 100));
    waitDone();
    applyStimulus(mkWin(0, 0, 10, 0, 0, 10, 0, 0, 10));
    waitDone();
    applyStimulus(mkWin(20, 20, 20, 0, 0, 0, 0, 0, 0));
    waitDone();
    applyStimulus(mkWin(0, 0, 255, 0, 0, 255, 0, 0, 255));
    waitDone();
    applyStimulus(mkWin(255, 255, 255, 255, 255, 255, 255, 255, 255));
    waitDone();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(mkWin(0, 0, 10, 0, 0, 10, 0, 0, 10));
    in_window = mkWin(20, 20, 20, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    waitValid();
    repeat (5) begin
      @(negedge clk);
      checkOutput("bpInReady", int'(in_ready), 0);
      checkOutput("bpData", int'(out_data), 40);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bpHandshakeValid", int'(out_valid), 1);
    @(negedge clk);
    checkOutput("bpIdleNext", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitDone();

    $display("[TB] reset during RUN_Y");
    applyStimulus(mkWin(0, 0, 255, 0, 0, 255, 0, 0, 255));
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midRstValid", int'(out_valid), 0);
    checkOutput("midRstSclr", int'(mac_sclr), 1);
    rst_n = 1'b1;
    #1;
    checkOutput("sclrBeforeEdge", int'(mac_sclr), 1);
    @(posedge clk);
    #1;
    checkOutput("sclrAfterEdge", int'(mac_sclr), 0);
    checkOutput("postRstReady", int'(in_ready), 1);
    applyStimulus(mkWin(100, 100, 100, 100, 100, 100, 100, 100, 100));
    waitDone();

    $display("[TB] random windows");
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 9; k++) begin
        w[k*8 +: 8] = (n % 2 == 0) ? 8'($urandom_range(0, 255))
                                   : (($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0);
      end
      out_ready = ($urandom_range(0, 1) == 1);
      applyStimulus(w);
      if (!out_ready) begin
        waitValid();
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      waitDone();
    end

    checkOutput("queueEmpty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
